// File: rtl/multistage_iir_lpf.sv
// Multi-channel cascaded one-pole IIR low-pass filter: y += (x - y) >>> shift per stage,
// stages evaluated one per cycle by a small FSM, guard-bit accumulators, rounded output.
module multistage_iir_lpf #(
    parameter int WIDTH     = 16,
    parameter int CHANNELS  = 2,
    parameter int STAGES    = 2,
    parameter int GUARD     = 4,
    parameter int SHIFT_W   = 5,
    parameter int MAX_SHIFT = 20
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [SHIFT_W-1:0]           shift_cfg,
    input  logic                         bypass,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHANNELS*WIDTH-1:0]    in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CHANNELS*WIDTH-1:0]    out_data
);

    localparam int AW = WIDTH + GUARD;
    localparam int DW = AW + 1;
    localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam logic [SW-1:0]        LAST_STG = SW'(STAGES - 1);
    localparam logic [SHIFT_W-1:0]   MAX_SH   = SHIFT_W'(MAX_SHIFT);
    localparam logic signed [DW-1:0] HALF     = DW'(2 ** (GUARD - 1));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                      state_r, state_s;
    logic [SW-1:0]               stg_r;
    logic [SHIFT_W-1:0]          shift_r;
    logic [CHANNELS*WIDTH-1:0]   data_r;
    logic signed [AW-1:0]        acc_r [STAGES][CHANNELS];

    logic                        accept_s;
    logic [SHIFT_W-1:0]          shift_clamp_s;
    logic [SW-1:0]               prev_stg_s;
    logic signed [AW-1:0]        x_a_s   [CHANNELS];
    logic signed [AW-1:0]        cur_a_s [CHANNELS];
    logic signed [DW-1:0]        x_e_s   [CHANNELS];
    logic signed [DW-1:0]        cur_e_s [CHANNELS];
    logic signed [DW-1:0]        d_s     [CHANNELS];
    logic signed [AW-1:0]        upd_s   [CHANNELS];
    logic signed [DW-1:0]        rnd_s   [CHANNELS];
    logic [CHANNELS*WIDTH-1:0]   rnd_data_s;

    assign in_ready      = (state_r == IDLE) & ~reset & ~clear;
    assign accept_s      = in_valid & in_ready;
    assign shift_clamp_s = (shift_cfg > MAX_SH) ? MAX_SH : shift_cfg;
    assign prev_stg_s    = stg_r - SW'(1);

    // One stage update for every channel; stage 0 takes the scaled input, later stages the previous acc.
    always_comb begin
        rnd_data_s = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            x_a_s[c]   = (stg_r == SW'(0)) ? $signed({data_r[c*WIDTH +: WIDTH], {GUARD{1'b0}}})
                                           : acc_r[prev_stg_s][c];
            cur_a_s[c] = acc_r[stg_r][c];
            x_e_s[c]   = {x_a_s[c][AW-1], x_a_s[c]};
            cur_e_s[c] = {cur_a_s[c][AW-1], cur_a_s[c]};
            d_s[c]     = x_e_s[c] - cur_e_s[c];
            // acc stays a convex combination of inputs, so the sum always fits in AW bits
            upd_s[c]   = cur_a_s[c] + AW'(d_s[c] >>> shift_r);
            rnd_s[c]   = {upd_s[c][AW-1], upd_s[c]} + HALF;
            rnd_data_s[c*WIDTH +: WIDTH] = WIDTH'(rnd_s[c] >>> GUARD);
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = bypass ? OUT : RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (stg_r == LAST_STG) begin
                    state_s = OUT;
                end else begin
                    state_s = RUN;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = OUT;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, sample latch, accumulators and registered outputs; clear behaves like reset here.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_r   <= IDLE;
            stg_r     <= '0;
            shift_r   <= '0;
            data_r    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int s = 0; s < STAGES; s++) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    acc_r[s][c] <= '0;
                end
            end
        end else begin
            state_r <= state_s;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        data_r  <= in_data;
                        shift_r <= shift_clamp_s;
                        stg_r   <= '0;
                        if (bypass) begin
                            out_data  <= in_data;
                            out_valid <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        acc_r[stg_r][c] <= upd_s[c];
                    end
                    if (stg_r == LAST_STG) begin
                        out_data  <= rnd_data_s;
                        out_valid <= 1'b1;
                    end else begin
                        stg_r <= stg_r + SW'(1);
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
